mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_rr_arb.sv | 47 ++++
 rtl/mult_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier arbiter.
package mult_pkg;

  localparam int MULT_N_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOADB,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_rr_arb.sv
// Grant selection for two requesters; round-robin when MULT_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 winning ties.
module mult_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_advance,
  input  logic             i_served,
  output logic [N_REQ-1:0] o_grant
);

`ifdef MULT_ARB_RR_EN
  logic r_ptr;

  // Pointer favours whichever requester was not served by the last operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= ~i_served;
    end
  end

  always_comb begin
    o_grant = '0;
    if (!r_ptr) begin
      if (i_req[0])      o_grant[0] = 1'b1;
      else if (i_req[1]) o_grant[1] = 1'b1;
    end else begin
      if (i_req[1])      o_grant[1] = 1'b1;
      else if (i_req[0]) o_grant[0] = 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_advance, i_served};

  always_comb begin
    o_grant = '0;
    if (i_req[0])      o_grant[0] = 1'b1;
    else if (i_req[1]) o_grant[1] = 1'b1;
  end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Control FSM for a shared X:A:B shift-add signed multiplier serving two requesters.
// Arbitration policy selected by MULT_ARB_RR_EN (see mult_rr_arb).
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS,
  parameter int N_REQ  = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_REQ-1:0] req,
  input  logic             M,
  output logic [N_REQ-1:0] gnt,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic             Clear_XA,
  output logic             Sub,
  output logic [N_REQ-1:0] done,
  output logic             busy
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  mult_state_t      r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_ldB;
  logic             r_shift;
  logic             r_clr;
  logic             r_busy;
  logic [N_REQ-1:0] w_grant;
  logic             w_advance;
  logic             w_served;

  assign w_advance = (r_state == DONE);
  assign w_served  = r_gnt[1];

  mult_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_req     (req),
    .i_advance (w_advance),
    .i_served  (w_served),
    .o_grant   (w_grant)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_ldB   <= 1'b0;
      r_shift <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ldB   <= 1'b0;
      r_shift <= 1'b0;
      r_clr   <= 1'b0;
      r_done  <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt   <= w_grant;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_ldB   <= 1'b1;
          r_cnt   <= '0;
          r_state <= LOADB;
        end
        LOADB: begin
          r_state <= ADD;
        end
        ADD: begin
          r_shift <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          // Counter saturates at the last iteration instead of wrapping.
          if (r_cnt < LAST) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ADD;
          end else begin
            r_done  <= r_gnt;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ld_A and Sub follow the live multiplier bit, so they cannot be registered.
  assign Ld_A     = (r_state == ADD) && M;
  assign Sub      = Ld_A && (r_cnt == LAST);
  assign Ld_B     = r_ldB;
  assign Shift_En = r_shift;
  assign Clear_XA = r_clr;
  assign gnt      = r_gnt;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter driving a behavioural X:A:B shift-add datapath.
module tb_mult_arbiter;

  localparam int NB     = 8;
  localparam int LAT    = 2 + 2 * NB + 1;
  localparam int SUB_AT = LAT - 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       M;
  logic [1:0] gnt;
  logic       Ld_A, Ld_B, Shift_En, Clear_XA, Sub;
  logic [1:0] done;
  logic       busy;

  logic       X = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [7:0] mcand [2];
  logic [7:0] mplier[2];
  logic [7:0] din;
  logic [8:0] sum;

  typedef struct {
    int          idx;
    logic [15:0] product;
    bit          expSub;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         gntCyc = 0;
  int         subCount = 0;
  int         subAt = 0;
  logic [1:0] firstGnt = 2'b00;
  logic [1:0] prevGnt = 2'b00;
  logic [1:0] oneHot;

  mult_arbiter #(.N_BITS(NB), .N_REQ(2)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req      (req),
    .M        (M),
    .gnt      (gnt),
    .Ld_A     (Ld_A),
    .Ld_B     (Ld_B),
    .Shift_En (Shift_En),
    .Clear_XA (Clear_XA),
    .Sub      (Sub),
    .done     (done),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  // Din carries the multiplier while B loads, otherwise the multiplicand.
  assign din = Ld_B ? mplier[gnt[1]] : mcand[gnt[1]];
  assign M   = B[0];
  assign sum = Sub ? ({A[7], A} - {din[7], din}) : ({A[7], A} + {din[7], din});

  always @(posedge Clk) begin
    if (Clear_XA) begin
      X <= 1'b0;
      A <= 8'h00;
    end else if (Ld_B) begin
      B <= din;
    end else if (Ld_A) begin
      X <= sum[8];
      A <= sum[7:0];
    end else if (Shift_En) begin
      A <= {X, A[7:1]};
      B <= {A[0], B[7:1]};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int idx, input logic [15:0] p, input bit s);
    exp_t x;
    x.idx = idx;
    x.product = p;
    x.expSub = s;
    sb.push_back(x);
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    req = r;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    do begin
      @(negedge Clk);
      #1;
      n++;
    end while (done == 2'b00 && n < budget);
    checkOutput("doneSeen", 32'(done != 2'b00), 32'd1);
  endtask

  task automatic waitGntCyc(input int target, input int budget);
    int n = 0;
    do begin
      @(negedge Clk);
      #1;
      n++;
    end while (gntCyc != target && n < budget);
    checkOutput("cycleReached", 32'(gntCyc == target), 32'd1);
  endtask

  // Monitor: per-cycle control invariants plus scoreboard pop on every done pulse.
  always @(negedge Clk) begin
    if (Reset) begin
      gntCyc   = 0;
      subCount = 0;
      subAt    = 0;
      prevGnt  = 2'b00;
    end else begin
      checkOutput("exclusive", 32'($countones({Ld_A, Ld_B, Shift_En, Clear_XA}) <= 1), 32'd1);
      if (busy) checkOutput("gntOneHot", 32'($onehot(gnt)), 32'd1);
      else      checkOutput("gntIdle", 32'(gnt), 32'd0);
      if (gnt != 2'b00 && prevGnt != 2'b00) checkOutput("gntStable", 32'(gnt), 32'(prevGnt));
      if (gnt != 2'b00) begin
        gntCyc++;
        if (gntCyc == 1) firstGnt = gnt;
        if (Sub) begin
          subCount++;
          subAt = gntCyc;
        end
      end else begin
        gntCyc   = 0;
        subCount = 0;
        subAt    = 0;
      end
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          oneHot = 2'b01 << e.idx;
          checkOutput("doneBit", 32'(done), 32'(oneHot));
          checkOutput("grant", 32'(firstGnt), 32'(oneHot));
          checkOutput("latency", 32'(gntCyc), 32'(LAT));
          checkOutput("product", 32'({A, B}), 32'(e.product));
          checkOutput("subCount", 32'(subCount), e.expSub ? 32'd1 : 32'd0);
          if (e.expSub) checkOutput("subCycle", 32'(subAt), 32'(SUB_AT));
        end
      end
      prevGnt = gnt;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mcand[0] = 8'h00; mplier[0] = 8'h00;
    mcand[1] = 8'h00; mplier[1] = 8'h00;

    repeat (2) @(negedge Clk);
    #1;
    checkOutput("resetOutputs", 32'({gnt, done, Ld_A, Ld_B, Shift_En, Clear_XA, Sub, busy}), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    #1;

    // 7 * 3 on requester 0
    mcand[0] = 8'h07; mplier[0] = 8'h03;
    pushExp(0, 16'h0015, 1'b0);
    applyStimulus(2'b01);
    @(posedge Clk);
    #1;
    checkOutput("gntNext", 32'(gnt), 32'd1);
    waitDone(40);
    applyStimulus(2'b00);
    @(negedge Clk);
    #1;

    // 2 * -1 on requester 1; B=0xFF so its sign bit triggers the final subtract
    mcand[1] = 8'h02; mplier[1] = 8'hFF;
    pushExp(1, 16'hFFFE, 1'b1);
    applyStimulus(2'b10);
    waitDone(40);
    applyStimulus(2'b00);
    @(negedge Clk);
    #1;

    // Both requesters held across two operations
    mcand[0] = 8'h06; mplier[0] = 8'h04;
    mcand[1] = 8'h03; mplier[1] = 8'hFD;
    pushExp(0, 16'h0018, 1'b0);
`ifdef MULT_ARB_RR_EN
    pushExp(1, 16'hFFF7, 1'b1);
`else
    pushExp(0, 16'h0018, 1'b0);
`endif
    applyStimulus(2'b11);
    waitDone(40);
    @(negedge Clk);
    #1;
    checkOutput("idleGap", 32'(busy), 32'd0);
    @(negedge Clk);
    #1;
    checkOutput("regrant", 32'(busy), 32'd1);
    waitDone(40);
    applyStimulus(2'b00);
    @(negedge Clk);
    #1;

    // Reset during the fifth SHIFT aborts without done
    mcand[0] = 8'h05; mplier[0] = 8'h09;
    applyStimulus(2'b01);
    waitGntCyc(12, 40);
    checkOutput("inFifthShift", 32'(Shift_En), 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("abortOutputs", 32'({gnt, done, Ld_A, Ld_B, Shift_En, Clear_XA, Sub, busy}), 32'd0);
    applyStimulus(2'b00);
    repeat (2) @(negedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    pushExp(0, 16'h002D, 1'b0);
    applyStimulus(2'b01);
    waitDone(40);
    applyStimulus(2'b00);
    @(negedge Clk);
    #1;

    // req[0] dropped during the ADD of iteration 3
    mcand[0] = 8'h0C; mplier[0] = 8'h0B;
    pushExp(0, 16'h0084, 1'b0);
    applyStimulus(2'b01);
    waitGntCyc(9, 40);
    checkOutput("addIter3", 32'(Ld_A), 32'd1);
    applyStimulus(2'b00);
    waitDone(40);
    @(negedge Clk);
    #1;
    checkOutput("idleAfter", 32'(busy), 32'd0);
    repeat (3) @(negedge Clk);
    #1;
    checkOutput("staysIdle", 32'(gnt), 32'd0);

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
